rtc_work_timer: RTL and testbench

//  Time-of-day clock plus NUM_CH independent work-time accumulators. Each channel
//  has a programmable reminder threshold and a sticky, acknowledgeable remind flag.

---
 rtl/rtc_work_timer_pkg.sv | 17 +
 rtl/rtc_work_timer_if.sv | 43 ++++
 rtl/rtc_work_timer_hms_counter.sv | 70 +++++++
 rtl/rtc_work_timer.sv | 136 +++++++++++++
 tb/tb_rtc_work_timer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_work_timer_pkg.sv
// Shared constants, counter mode and packed-bus helpers for the RTC / work-time timer.
package rtc_pkg;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

  typedef enum logic {
    HMS_WRAP = 1'b0,
    HMS_SAT  = 1'b1
  } hms_mode_e;

  // Low bit index of element idx in a packed vector of width-wide elements.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rtc_work_timer_if.sv
// Control/status bundle between the appliance FSM, the timer and the display/alarm logic.
interface rtc_work_timer_if #(
  parameter int NUM_CH  = 2,
  parameter int WORK_HW = 6
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                      power_on;
  logic                      tod_load;
  logic [4:0]                tod_load_h;
  logic [5:0]                tod_load_m;
  logic                      tod_load_err;
  logic [4:0]                hour;
  logic [5:0]                minute;
  logic [5:0]                second;
  logic                      sec_tick;
  logic [NUM_CH-1:0]         ch_run;
  logic [NUM_CH-1:0]         ch_clear;
  logic                      thr_we;
  logic [CH_W-1:0]           thr_ch;
  logic [WORK_HW-1:0]        thr_h;
  logic [5:0]                thr_m;
  logic [NUM_CH*WORK_HW-1:0] work_hours;
  logic [NUM_CH*6-1:0]       work_minutes;
  logic [NUM_CH*6-1:0]       work_seconds;
  logic [NUM_CH-1:0]         remind;
  logic [NUM_CH-1:0]         remind_ack;

  modport master (
    output power_on, tod_load, tod_load_h, tod_load_m, ch_run, ch_clear,
           thr_we, thr_ch, thr_h, thr_m, remind_ack,
    input  tod_load_err, hour, minute, second, sec_tick,
           work_hours, work_minutes, work_seconds, remind
  );

  modport slave (
    input  power_on, tod_load, tod_load_h, tod_load_m, ch_run, ch_clear,
           thr_we, thr_ch, thr_h, thr_m, remind_ack,
    output tod_load_err, hour, minute, second, sec_tick,
           work_hours, work_minutes, work_seconds, remind
  );

endinterface

// File: rtl/rtc_work_timer_hms_counter.sv
// Hours:minutes:seconds counter; wraps at HOUR_MAX-1:59:59 or saturates there.
module hms_counter
  import rtc_pkg::*;
#(
  parameter int        HW       = 5,
  parameter int        HOUR_MAX = 24,
  parameter hms_mode_e MODE     = HMS_WRAP
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          load,
  input  logic [HW-1:0] ld_h,
  input  logic [5:0]    ld_m,
  input  logic          inc,
  output logic [HW-1:0] h,
  output logic [5:0]    m,
  output logic [5:0]    s
);

  logic [HW-1:0] h_q, h_d;
  logic [5:0]    m_q, m_d;
  logic [5:0]    s_q, s_d;
  logic          s_top, m_top, h_top, at_sat;

  always_comb begin
    s_top  = (s_q == 6'(SEC_MAX));
    m_top  = (m_q == 6'(MIN_MAX));
    h_top  = (32'(h_q) == 32'(HOUR_MAX - 1));
    at_sat = (MODE == HMS_SAT) && h_top && m_top && s_top;
    h_d = h_q;
    m_d = m_q;
    s_d = s_q;
    // clear beats load beats increment
    if (clr) begin
      h_d = '0;
      m_d = '0;
      s_d = '0;
    end else if (load) begin
      h_d = ld_h;
      m_d = ld_m;
      s_d = '0;
    end else if (inc && !at_sat) begin
      s_d = s_top ? 6'd0 : s_q + 6'd1;
      if (s_top) begin
        m_d = m_top ? 6'd0 : m_q + 6'd1;
        if (m_top) begin
          h_d = h_top ? '0 : h_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q <= '0;
      m_q <= '0;
      s_q <= '0;
    end else begin
      h_q <= h_d;
      m_q <= m_d;
      s_q <= s_d;
    end
  end

  assign h = h_q;
  assign m = m_q;
  assign s = s_q;

endmodule

// File: rtl/rtc_work_timer.sv
// Time-of-day clock plus NUM_CH saturating work-time accumulators with threshold reminders.
module rtc_work_timer
  import rtc_pkg::*;
#(
  parameter int CLK_DIV      = 100_000_000,
  parameter int NUM_CH       = 2,
  parameter int HOUR_MAX     = 24,
  parameter int WORK_HW      = 6,
  parameter int REMIND_H_DEF = 10
) (
  input logic             clk,
  input logic             reset,
  rtc_work_timer_if.slave bus
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] presc_q, presc_d;
  logic             tick_q, tick_d;
  logic             load_err_q, load_err_d;
  logic             load_ok;
  logic             tod_inc;
  logic             thr_ok;

  always_comb begin
    presc_d    = (presc_q == CNT_W'(CLK_DIV - 1)) ? '0 : presc_q + 1'b1;
    tick_d     = (presc_d == CNT_W'(CLK_DIV - 1));
    load_ok    = bus.tod_load && (32'(bus.tod_load_h) < 32'(HOUR_MAX))
                 && (32'(bus.tod_load_m) <= 32'(MIN_MAX));
    load_err_d = bus.tod_load && !load_ok;
    tod_inc    = tick_q && bus.power_on;
    thr_ok     = bus.thr_we && (32'(bus.thr_ch) < 32'(NUM_CH))
                 && (32'(bus.thr_m) <= 32'(MIN_MAX));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q    <= '0;
      tick_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.sec_tick     = tick_q;
  assign bus.tod_load_err = load_err_q;

  hms_counter #(
    .HW       (5),
    .HOUR_MAX (HOUR_MAX),
    .MODE     (HMS_WRAP)
  ) u_tod (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .load  (load_ok),
    .ld_h  (bus.tod_load_h),
    .ld_m  (bus.tod_load_m),
    .inc   (tod_inc),
    .h     (bus.hour),
    .m     (bus.minute),
    .s     (bus.second)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [WORK_HW-1:0] cnt_h;
      logic [5:0]         cnt_m, cnt_s;
      logic [WORK_HW-1:0] thr_h_q, thr_h_d;
      logic [5:0]         thr_m_q, thr_m_d;
      logic               above, above_q;
      logic               remind_q, remind_d;

      hms_counter #(
        .HW       (WORK_HW),
        .HOUR_MAX (2 ** WORK_HW),
        .MODE     (HMS_SAT)
      ) u_work (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.ch_clear[gi]),
        .load  (1'b0),
        .ld_h  ('0),
        .ld_m  ('0),
        .inc   (tick_q && bus.ch_run[gi]),
        .h     (cnt_h),
        .m     (cnt_m),
        .s     (cnt_s)
      );

      // A zero threshold disables the reminder; the minutes field is always < 60,
      // so the concatenation compares as a single hh:mm value.
      always_comb begin
        thr_h_d = thr_h_q;
        thr_m_d = thr_m_q;
        if (thr_ok && (32'(bus.thr_ch) == gi)) begin
          thr_h_d = bus.thr_h;
          thr_m_d = bus.thr_m;
        end
        above    = ({cnt_h, cnt_m} >= {thr_h_q, thr_m_q}) && (|{thr_h_q, thr_m_q});
        remind_d = remind_q;
        if (bus.ch_clear[gi]) begin
          remind_d = 1'b0;
        end else if (above && !above_q) begin
          remind_d = 1'b1;
        end else if (bus.remind_ack[gi]) begin
          remind_d = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          thr_h_q  <= WORK_HW'(REMIND_H_DEF);
          thr_m_q  <= '0;
          above_q  <= 1'b0;
          remind_q <= 1'b0;
        end else begin
          thr_h_q  <= thr_h_d;
          thr_m_q  <= thr_m_d;
          above_q  <= above;
          remind_q <= remind_d;
        end
      end

      assign bus.work_hours[slice_lo(gi, WORK_HW) +: WORK_HW] = cnt_h;
      assign bus.work_minutes[slice_lo(gi, 6) +: 6]           = cnt_m;
      assign bus.work_seconds[slice_lo(gi, 6) +: 6]           = cnt_s;
      assign bus.remind[gi]                                   = remind_q;
    end
  endgenerate

endmodule

// File: tb/tb_rtc_work_timer.sv
// Directed bench: dut1 uses the default channel layout, dut2 a 3-channel, 2-bit-hour variant.
module tb_rtc_work_timer;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  rtc_work_timer_if #(.NUM_CH(2), .WORK_HW(6)) bus1 ();
  rtc_work_timer_if #(.NUM_CH(3), .WORK_HW(2)) bus2 ();

  rtc_work_timer #(
    .CLK_DIV(4), .NUM_CH(2), .HOUR_MAX(24), .WORK_HW(6), .REMIND_H_DEF(10)
  ) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  rtc_work_timer #(
    .CLK_DIV(4), .NUM_CH(3), .HOUR_MAX(24), .WORK_HW(2), .REMIND_H_DEF(3)
  ) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  function automatic logic [31:0] pk(input int h, input int m, input int s);
    return {8'd0, 8'(h), 8'(m), 8'(s)};
  endfunction

  function automatic logic [31:0] tod1();
    return pk(int'(bus1.hour), int'(bus1.minute), int'(bus1.second));
  endfunction

  function automatic logic [31:0] wk1(input int i);
    return pk(int'(bus1.work_hours[i*6 +: 6]), int'(bus1.work_minutes[i*6 +: 6]),
              int'(bus1.work_seconds[i*6 +: 6]));
  endfunction

  function automatic logic [31:0] wk2(input int i);
    return pk(int'(bus2.work_hours[i*2 +: 2]), int'(bus2.work_minutes[i*6 +: 6]),
              int'(bus2.work_seconds[i*6 +: 6]));
  endfunction

  // Returns at the negedge where the n-th further sec_tick is high (not yet applied).
  task automatic wait_ticks(input int n, input bit use2);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!(use2 ? bus2.sec_tick : bus1.sec_tick) && guard < 10);
      if (guard >= 10) begin
        n_fail++;
        $display("FAIL tick_timeout: no sec_tick within %0d cycles, required one", guard);
        return;
      end
    end
  endtask

  // Leaves the bench one cycle after a dut1 tick, so stimulus set now precedes the next tick.
  task automatic sync();
    wait_ticks(1, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    {bus1.power_on, bus1.tod_load, bus1.tod_load_h, bus1.tod_load_m} = '0;
    {bus1.ch_run, bus1.ch_clear, bus1.thr_we, bus1.thr_ch, bus1.thr_h, bus1.thr_m} = '0;
    bus1.remind_ack = '0;
    {bus2.power_on, bus2.tod_load, bus2.tod_load_h, bus2.tod_load_m} = '0;
    {bus2.ch_run, bus2.ch_clear, bus2.thr_we, bus2.thr_ch, bus2.thr_h, bus2.thr_m} = '0;
    bus2.remind_ack = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // reset state and first tick position
    check("rst_tod", tod1(), pk(0, 0, 0));
    check("rst_work_ch0", wk1(0), pk(0, 0, 0));
    check("rst_work_ch1", wk1(1), pk(0, 0, 0));
    check("rst_remind", 32'(bus1.remind), 0);
    check("rst_load_err", 32'(bus1.tod_load_err), 0);
    @(negedge clk); check("tick_c1", 32'(bus1.sec_tick), 0);
    @(negedge clk); check("tick_c2", 32'(bus1.sec_tick), 0);
    @(negedge clk); check("tick_c3", 32'(bus1.sec_tick), 1);
    @(negedge clk); check("tick_c4", 32'(bus1.sec_tick), 0);

    // dut2: invalid channel write ignored, ch2 threshold 0:01, then saturation
    bus2.thr_we = 1'b1; bus2.thr_ch = 2'd3; bus2.thr_h = 2'd0; bus2.thr_m = 6'd1;
    @(negedge clk);
    bus2.thr_ch = 2'd2;
    @(negedge clk);
    bus2.thr_we = 1'b0;
    bus2.ch_run = 3'b111;
    wait_ticks(60, 1'b1);
    @(negedge clk);
    check("d2_ch2_1min", wk2(2), pk(0, 1, 0));
    check("d2_ch0_1min", wk2(0), pk(0, 1, 0));
    check("d2_remind_pre", 32'(bus2.remind), 0);
    @(negedge clk);
    check("d2_remind_ch2", 32'(bus2.remind), 4);
    bus2.ch_clear = 3'b110; bus2.ch_run = 3'b001;
    @(negedge clk);
    bus2.ch_clear = 3'b000;
    check("d2_clr_ch1", wk2(1), pk(0, 0, 0));
    check("d2_clr_remind", 32'(bus2.remind), 0);
    wait_ticks(14350, 1'b1);
    @(negedge clk);
    check("d2_sat_hold", wk2(0), pk(3, 59, 59));
    check("d2_remind_ch0", 32'(bus2.remind), 1);
    wait_ticks(1, 1'b1);
    bus2.ch_clear = 3'b001;
    @(negedge clk);
    bus2.ch_clear = 3'b000; bus2.ch_run = 3'b000;
    check("d2_clr_run_tick", wk2(0), pk(0, 0, 0));
    check("d2_clr_remind0", 32'(bus2.remind), 0);

    // time of day: wrap 23:59:59 -> 00:00:00, then hold with power off
    sync();
    bus1.power_on = 1'b1;
    bus1.tod_load = 1'b1; bus1.tod_load_h = 5'd23; bus1.tod_load_m = 6'd59;
    @(negedge clk);
    bus1.tod_load = 1'b0;
    check("tod_load", tod1(), pk(23, 59, 0));
    wait_ticks(59, 1'b0);
    @(negedge clk);
    check("tod_59s", tod1(), pk(23, 59, 59));
    wait_ticks(1, 1'b0);
    @(negedge clk);
    check("tod_wrap", tod1(), pk(0, 0, 0));
    bus1.power_on = 1'b0;
    wait_ticks(5, 1'b0);
    @(negedge clk);
    check("tod_power_off", tod1(), pk(0, 0, 0));

    // out-of-range loads
    bus1.tod_load = 1'b1; bus1.tod_load_h = 5'd24; bus1.tod_load_m = 6'd0;
    @(negedge clk);
    bus1.tod_load = 1'b0;
    check("err_h24", 32'(bus1.tod_load_err), 1);
    check("err_h24_tod", tod1(), pk(0, 0, 0));
    @(negedge clk);
    check("err_h24_pulse", 32'(bus1.tod_load_err), 0);
    bus1.tod_load = 1'b1; bus1.tod_load_h = 5'd5; bus1.tod_load_m = 6'd60;
    @(negedge clk);
    bus1.tod_load = 1'b0;
    check("err_m60", 32'(bus1.tod_load_err), 1);
    check("err_m60_tod", tod1(), pk(0, 0, 0));
    @(negedge clk);
    check("err_m60_pulse", 32'(bus1.tod_load_err), 0);

    // channel 0 reminder at 0:01; the 0:60 write must be rejected
    bus1.thr_we = 1'b1; bus1.thr_ch = 1'b0; bus1.thr_h = 6'd0; bus1.thr_m = 6'd1;
    @(negedge clk);
    bus1.thr_m = 6'd60;
    @(negedge clk);
    bus1.thr_we = 1'b0;
    sync();
    bus1.ch_run = 2'b01;
    wait_ticks(60, 1'b0);
    @(negedge clk);
    check("ch0_1min", wk1(0), pk(0, 1, 0));
    check("ch1_idle", wk1(1), pk(0, 0, 0));
    check("remind_latency", 32'(bus1.remind), 0);
    @(negedge clk);
    check("remind_set", 32'(bus1.remind), 1);
    bus1.remind_ack = 2'b01;
    @(negedge clk);
    bus1.remind_ack = 2'b00;
    check("remind_ack", 32'(bus1.remind), 0);
    wait_ticks(3, 1'b0);
    @(negedge clk);
    check("ack_running", wk1(0), pk(0, 1, 3));
    check("ack_stays_0", 32'(bus1.remind), 0);
    bus1.ch_clear = 2'b01; bus1.ch_run = 2'b00;
    @(negedge clk);
    bus1.ch_clear = 2'b00;
    check("ch0_clear", wk1(0), pk(0, 0, 0));
    sync();
    bus1.ch_run = 2'b01;
    wait_ticks(60, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("remind_rearm", 32'(bus1.remind), 1);

    // load coincident with a tick, then reset in the middle of counting
    bus1.power_on = 1'b1;
    wait_ticks(1, 1'b0);
    bus1.tod_load = 1'b1; bus1.tod_load_h = 5'd12; bus1.tod_load_m = 6'd34;
    @(negedge clk);
    bus1.tod_load = 1'b0;
    check("load_on_tick", tod1(), pk(12, 34, 0));
    check("load_on_tick_err", 32'(bus1.tod_load_err), 0);
    wait_ticks(5, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_tod", tod1(), pk(0, 0, 0));
    check("midrst_ch0", wk1(0), pk(0, 0, 0));
    check("midrst_remind", 32'(bus1.remind), 0);
    check("midrst_tick", 32'(bus1.sec_tick), 0);
    wait_ticks(60, 1'b0);
    @(negedge clk);
    check("post_rst_ch0", wk1(0), pk(0, 1, 0));
    check("post_rst_tod", tod1(), pk(0, 1, 0));
    @(negedge clk);
    check("thr_restored", 32'(bus1.remind), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
